// File: rtl/mux4_rr_feeder_pkg.sv
// Shared constants and types for the 4:1 mux feeder family.
package mux4_rr_feeder_pkg;

  localparam int MUX_WIDTH = 20;
  localparam int MUX_NCH   = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_feeder_rr_arb4.sv
// Combinational 4-way round-robin picker: first set request after LastGrant wins.
module rr_arb4
  import mux4_rr_feeder_pkg::*;
(
  input  logic [3:0]       Full,
  input  logic [SEL_W-1:0] LastGrant,
  output logic [SEL_W-1:0] Winner,
  output logic             AnyReq
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Walk LastGrant+1 .. LastGrant+4 (mod 4); the 2-bit add provides the wrap.
  always_comb begin
    Winner = LastGrant;
    AnyReq = |Full;
    found  = 1'b0;
    idx    = LastGrant;
    for (int k = 1; k <= 4; k++) begin
      idx = LastGrant + SEL_W'(k);
      if (!found && Full[idx]) begin
        Winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_feeder.sv
// Feeder for a combinational 20-bit 4:1 mux: one buffered word per channel,
// round-robin grant, valid/ready handshake toward a single consumer.
module mux4_rr_feeder
  import mux4_rr_feeder_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int NCH   = MUX_NCH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] InData0,
  input  logic [WIDTH-1:0] InData1,
  input  logic [WIDTH-1:0] InData2,
  input  logic [WIDTH-1:0] InData3,
  input  logic [NCH-1:0]   InValid,
  output logic [NCH-1:0]   InAck,
  output logic [WIDTH-1:0] Hold0,
  output logic [WIDTH-1:0] Hold1,
  output logic [WIDTH-1:0] Hold2,
  output logic [WIDTH-1:0] Hold3,
  output logic [SEL_W-1:0] Select,
  output logic             OutValid,
  input  logic             OutReady
);

  state_t                     state;
  logic [NCH-1:0]             full;
  logic [NCH-1:0][WIDTH-1:0]  din;
  logic [NCH-1:0][WIDTH-1:0]  hold_q;
  logic [SEL_W-1:0]           last_grant;
  logic [SEL_W-1:0]           winner;
  logic                       any_req;
  logic                       xfer;

  assign din[0] = InData0;
  assign din[1] = InData1;
  assign din[2] = InData2;
  assign din[3] = InData3;

  assign Hold0 = hold_q[0];
  assign Hold1 = hold_q[1];
  assign Hold2 = hold_q[2];
  assign Hold3 = hold_q[3];

  // A transfer only happens from PRESENT; OutReady is ignored otherwise.
  assign xfer = (state == PRESENT) && OutReady;

  rr_arb4 u_arb (
    .Full      (full),
    .LastGrant (last_grant),
    .Winner    (winner),
    .AnyReq    (any_req)
  );

  // Per-channel capture. Capture needs !full, and a free only hits a full slot,
  // so the two never collide; a freed slot refills no earlier than next cycle.
  // hold_q is frozen while full, which keeps the mux output stable while presented.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q <= '0;
      full   <= '0;
      InAck  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        InAck[i] <= InValid[i] && !full[i];
        if (InValid[i] && !full[i]) begin
          hold_q[i] <= din[i];
          full[i]   <= 1'b1;
        end else if (xfer && (Select == SEL_W'(i))) begin
          full[i]   <= 1'b0;
        end
      end
    end
  end

  // Grant FSM: arbitrate on registered full bits in IDLE, present until accepted.
  // last_grant resets to 3 so channel 0 is first in line.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      Select     <= '0;
      OutValid   <= 1'b0;
      last_grant <= SEL_W'(3);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            Select   <= winner;
            OutValid <= 1'b1;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (OutReady) begin
            last_grant <= Select;
            OutValid   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
